// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if
// Groups the per-channel plot request bus and the vga_adapter pixel bus.
//   req_valid/req_ready : per-channel handshake, one bit per channel
//   req_x/req_y/req_colour : packed per-channel request fields, channel i at [i*W +: W]
//   vga_x/vga_y/vga_colour/vga_plot : registered pixel write toward vga_adapter
// master = drawing clients + adapter side, slave = the arbiter.
interface vga_plot_arbiter_if #(
  parameter int NUM_CH   = 2,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic [NUM_CH-1:0]          req_valid;
  logic [NUM_CH-1:0]          req_ready;
  logic [NUM_CH*X_W-1:0]      req_x;
  logic [NUM_CH*Y_W-1:0]      req_y;
  logic [NUM_CH*COLOUR_W-1:0] req_colour;
  logic [X_W-1:0]             vga_x;
  logic [Y_W-1:0]             vga_y;
  logic [COLOUR_W-1:0]        vga_colour;
  logic                       vga_plot;

  modport master (
    output req_valid, req_x, req_y, req_colour,
    input  req_ready, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  req_valid, req_x, req_y, req_colour,
    output req_ready, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
// Front end for vga_adapter: per-channel request FIFOs, coordinate clipping,
// round-robin arbitration and a full-screen clear sweep. At most one registered
// pixel write per cycle.
// Ports:
//   clock, resetn  : clock (rising edge), asynchronous active-low reset
//   bus            : request handshake + adapter pixel bus (slave modport)
//   clear_start    : pulse, starts a clear sweep when idle
//   clear_colour   : colour for the sweep, sampled with clear_start
//   clear_busy     : high while the sweep runs
//   drop_count     : saturating count of clipped (out-of-range) requests
//
// state   | meaning
// S_IDLE  | arbitrate non-empty FIFOs, pop one winner per cycle
// S_CLEAR | sweep every pixel row-major in the latched colour, no pops
module vga_plot_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                resetn,
  vga_plot_arbiter_if.slave   bus,
  input  logic                clear_start,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_busy,
  output logic [15:0]         drop_count
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int E_W = X_W + Y_W + COLOUR_W;
  localparam logic [31:0] X_LIM = 32'(X_MAX);
  localparam logic [31:0] Y_LIM = 32'(Y_MAX);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  state_t state, state_n;

  logic [E_W-1:0]    mem [NUM_CH][FIFO_DEPTH];
  logic [AW:0]       wr_ptr [NUM_CH];
  logic [AW:0]       rd_ptr [NUM_CH];
  logic [NUM_CH-1:0] full, empty, accept, drop, push, pop;
  logic [CW-1:0]     rr_ptr, grant_idx, cand;
  logic              grant_any;
  logic              do_pop, start_clear, sweep_last;
  logic [X_W-1:0]    cx;
  logic [Y_W-1:0]    cy;
  logic [COLOUR_W-1:0] clr_col;
  logic              pend_valid;
  logic [E_W-1:0]    pend_data;
  logic [4:0]        drop_sum;
  logic [16:0]       drop_acc;

  // FIFO status, accept and clip decode. Ready never depends on a same-cycle pop.
  always_comb begin
    full   = '0;
    empty  = '0;
    accept = '0;
    drop   = '0;
    push   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]   = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                  (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      empty[i]  = (wr_ptr[i] == rd_ptr[i]);
      accept[i] = bus.req_valid[i] && !full[i];
      drop[i]   = accept[i] &&
                  ((32'(bus.req_x[i*X_W +: X_W]) > X_LIM) ||
                   (32'(bus.req_y[i*Y_W +: Y_W]) > Y_LIM));
      push[i]   = accept[i] && !drop[i];
    end
  end

  assign bus.req_ready = ~full;

  // First non-empty channel strictly after the last winner.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CW'((int'(rr_ptr) + k) % NUM_CH);
      if (!grant_any && !empty[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_n     = state;
    do_pop      = 1'b0;
    start_clear = 1'b0;
    sweep_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_start) begin
          state_n     = S_CLEAR;
          start_clear = 1'b1;
        end else begin
          do_pop = grant_any;
        end
      end
      S_CLEAR: begin
        sweep_last = (cx == X_W'(X_MAX)) && (cy == Y_W'(Y_MAX));
        if (sweep_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) pop[i] = do_pop && (grant_idx == CW'(i));
  end

  // Several channels may drop on one edge; they are summed before saturating.
  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_CH; i++) drop_sum = drop_sum + 5'(drop[i]);
    drop_acc = {1'b0, drop_count} + 17'(drop_sum);
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i])
        mem[i][wr_ptr[i][AW-1:0]] <= {bus.req_x[i*X_W +: X_W],
                                      bus.req_y[i*Y_W +: Y_W],
                                      bus.req_colour[i*COLOUR_W +: COLOUR_W]};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      rr_ptr         <= CW'(NUM_CH - 1);
      pend_valid     <= 1'b0;
      pend_data      <= '0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
      clear_busy     <= 1'b0;
      drop_count     <= '0;
      cx             <= '0;
      cy             <= '0;
      clr_col        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      state      <= state_n;
      clear_busy <= (state_n == S_CLEAR);

      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end

      if (start_clear) begin
        clr_col <= clear_colour;
        cx      <= '0;
        cy      <= '0;
      end else if (state == S_CLEAR) begin
        if (cx == X_W'(X_MAX)) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end

      // Popped entry is staged for one cycle, then driven to the adapter.
      if (state == S_CLEAR) begin
        bus.vga_plot   <= 1'b1;
        bus.vga_x      <= cx;
        bus.vga_y      <= cy;
        bus.vga_colour <= clr_col;
      end else begin
        bus.vga_plot <= pend_valid;
        if (pend_valid) {bus.vga_x, bus.vga_y, bus.vga_colour} <= pend_data;
      end

      pend_valid <= do_pop;
      if (do_pop) begin
        pend_data <= mem[grant_idx][rd_ptr[grant_idx][AW-1:0]];
        rr_ptr    <= grant_idx;
      end

      drop_count <= drop_acc[16] ? 16'hFFFF : drop_acc[15:0];
    end
  end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter
// Two arbiters: a full-size screen (160x120) and a tiny one (4x2) for sweep
// and mid-sweep reset scenarios. A queue-based reference model tracks each one
// and is compared every cycle; directed scenarios add literal expectations.
module tb_vga_plot_arbiter;
  localparam int NC = 2;
  localparam int DEPTH = 4;

  typedef struct {
    int cyc;
    int x;
    int y;
    int c;
  } plot_t;

  logic clock = 1'b0;
  logic rn_b = 1'b0;
  logic rn_s = 1'b0;
  logic clr_start_b = 1'b0, clr_start_s = 1'b0;
  logic [2:0] clr_col_b = '0, clr_col_s = '0;
  logic busy_b, busy_s;
  logic [15:0] drop_b, drop_s;

  vga_plot_arbiter_if #(.NUM_CH(2), .X_W(8), .Y_W(7), .COLOUR_W(3)) if_b ();
  vga_plot_arbiter_if #(.NUM_CH(2), .X_W(8), .Y_W(7), .COLOUR_W(3)) if_s ();

  vga_plot_arbiter #(.NUM_CH(2), .X_W(8), .Y_W(7), .COLOUR_W(3),
                     .X_MAX(159), .Y_MAX(119), .FIFO_DEPTH(DEPTH)) u_big (
    .clock(clock), .resetn(rn_b), .bus(if_b),
    .clear_start(clr_start_b), .clear_colour(clr_col_b),
    .clear_busy(busy_b), .drop_count(drop_b)
  );

  vga_plot_arbiter #(.NUM_CH(2), .X_W(8), .Y_W(7), .COLOUR_W(3),
                     .X_MAX(3), .Y_MAX(1), .FIFO_DEPTH(DEPTH)) u_small (
    .clock(clock), .resetn(rn_s), .bus(if_s),
    .clear_start(clr_start_s), .clear_colour(clr_col_s),
    .clear_busy(busy_s), .drop_count(drop_s)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int xmax [2] = '{159, 3};
  int ymax [2] = '{119, 1};
  int mq [2][NC][$];
  int m_rr [2];
  bit m_stv [2];
  int m_st [2];
  bit m_clr [2];
  int m_idx [2];
  int m_col [2];
  int m_drops [2];
  bit m_plot [2];
  int m_x [2];
  int m_y [2];
  int m_c [2];

  task automatic model_reset(input int n);
    for (int i = 0; i < NC; i++) mq[n][i].delete();
    m_rr[n] = NC - 1;
    m_stv[n] = 0;
    m_st[n] = 0;
    m_clr[n] = 0;
    m_idx[n] = 0;
    m_col[n] = 0;
    m_drops[n] = 0;
    m_plot[n] = 0;
    m_x[n] = 0;
    m_y[n] = 0;
    m_c[n] = 0;
  endtask

  task automatic model_step(input int n, input logic [1:0] v, input logic [15:0] xs,
                            input logic [13:0] ys, input logic [5:0] cs,
                            input logic st, input logic [2:0] col);
    bit rdy [NC];
    int g;
    int w;
    int nd;
    w = xmax[n] + 1;
    for (int i = 0; i < NC; i++) rdy[i] = mq[n][i].size() < DEPTH;
    if (m_clr[n]) begin
      m_plot[n] = 1;
      m_x[n] = m_idx[n] % w;
      m_y[n] = m_idx[n] / w;
      m_c[n] = m_col[n];
      m_idx[n]++;
      if (m_idx[n] == w * (ymax[n] + 1)) m_clr[n] = 0;
    end else begin
      m_plot[n] = m_stv[n];
      if (m_stv[n]) begin
        m_x[n] = (m_st[n] >> 16) & 255;
        m_y[n] = (m_st[n] >> 8) & 255;
        m_c[n] = m_st[n] & 255;
      end
      m_stv[n] = 0;
      if (st) begin
        m_clr[n] = 1;
        m_idx[n] = 0;
        m_col[n] = int'(col);
      end else begin
        g = -1;
        for (int k = 1; k <= NC; k++)
          if (g < 0 && mq[n][(m_rr[n] + k) % NC].size() > 0) g = (m_rr[n] + k) % NC;
        if (g >= 0) begin
          m_st[n] = mq[n][g].pop_front();
          m_stv[n] = 1;
          m_rr[n] = g;
        end
      end
    end
    nd = 0;
    for (int i = 0; i < NC; i++) begin
      if (v[i] && rdy[i]) begin
        int x;
        int y;
        int c;
        x = int'(xs[i*8 +: 8]);
        y = int'(ys[i*7 +: 7]);
        c = int'(cs[i*3 +: 3]);
        if (x > xmax[n] || y > ymax[n]) nd++;
        else mq[n][i].push_back(x * 65536 + y * 256 + c);
      end
    end
    m_drops[n] = (m_drops[n] + nd > 65535) ? 65535 : m_drops[n] + nd;
  endtask

  always @(posedge clock) begin
    cyc++;
    if (!rn_b) model_reset(0);
    else model_step(0, if_b.req_valid, if_b.req_x, if_b.req_y, if_b.req_colour,
                    clr_start_b, clr_col_b);
    if (!rn_s) model_reset(1);
    else model_step(1, if_s.req_valid, if_s.req_x, if_s.req_y, if_s.req_colour,
                    clr_start_s, clr_col_s);
  end

  // ---------------- per-cycle compare ----------------
  plot_t log_b [$];
  plot_t log_s [$];

  task automatic compare_inst(input int n, input string p, input logic plot,
                              input int x, input int y, input int c,
                              input logic [1:0] rdy, input logic busy, input int drop);
    int er;
    er = ((mq[n][1].size() < DEPTH) ? 2 : 0) + ((mq[n][0].size() < DEPTH) ? 1 : 0);
    check({p, ".vga_plot"}, int'(plot), int'(m_plot[n]));
    check({p, ".vga_x"}, x, m_x[n]);
    check({p, ".vga_y"}, y, m_y[n]);
    check({p, ".vga_colour"}, c, m_c[n]);
    check({p, ".req_ready"}, int'(rdy), er);
    check({p, ".clear_busy"}, int'(busy), int'(m_clr[n]));
    check({p, ".drop_count"}, drop, m_drops[n]);
  endtask

  always @(negedge clock) begin
    plot_t e;
    if (rn_b) begin
      compare_inst(0, "big", if_b.vga_plot, int'(if_b.vga_x), int'(if_b.vga_y),
                   int'(if_b.vga_colour), if_b.req_ready, busy_b, int'(drop_b));
      if (if_b.vga_plot) begin
        e.cyc = cyc; e.x = int'(if_b.vga_x); e.y = int'(if_b.vga_y); e.c = int'(if_b.vga_colour);
        log_b.push_back(e);
      end
    end
    if (rn_s) begin
      compare_inst(1, "small", if_s.vga_plot, int'(if_s.vga_x), int'(if_s.vga_y),
                   int'(if_s.vga_colour), if_s.req_ready, busy_s, int'(drop_s));
      if (if_s.vga_plot) begin
        e.cyc = cyc; e.x = int'(if_s.vga_x); e.y = int'(if_s.vga_y); e.c = int'(if_s.vga_colour);
        log_s.push_back(e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_b(input int ch, input int x, input int y, input int c);
    logic [7:0] xv;
    logic [6:0] yv;
    logic [2:0] cv;
    xv = x[7:0];
    yv = y[6:0];
    cv = c[2:0];
    if_b.req_x[ch*8 +: 8] = xv;
    if_b.req_y[ch*7 +: 7] = yv;
    if_b.req_colour[ch*3 +: 3] = cv;
  endtask

  task automatic reset_big();
    rn_b = 1'b0;
    tick();
    rn_b = 1'b1;
    log_b.delete();
  endtask

  initial begin
    int k;
    int acc;
    int guard;
    int bcnt;
    bit chk4;
    bit r;
    plot_t sel [$];

    if_b.req_valid = '0; if_b.req_x = '0; if_b.req_y = '0; if_b.req_colour = '0;
    if_s.req_valid = '0; if_s.req_x = '0; if_s.req_y = '0; if_s.req_colour = '0;
    repeat (3) tick();
    rn_b = 1'b1;
    rn_s = 1'b1;

    @(negedge clock);
    check("reset_plot", int'(if_b.vga_plot), 0);
    check("reset_ready", int'(if_b.req_ready), 3);
    check("reset_busy", int'(busy_b), 0);
    check("reset_drop", int'(drop_b), 0);
    tick();

    // single request: accepted at edge k, visible after edge k+2 for one cycle
    log_b.delete();
    drive_b(0, 10, 20, 5);
    if_b.req_valid = 2'b01;
    tick();
    k = cyc;
    if_b.req_valid = 2'b00;
    repeat (6) tick();
    check("t1_plot_count", log_b.size(), 1);
    if (log_b.size() == 1) begin
      check("t1_latency", log_b[0].cyc, k + 2);
      check("t1_x", log_b[0].x, 10);
      check("t1_y", log_b[0].y, 20);
      check("t1_colour", log_b[0].c, 5);
    end
    check("t1_drop", int'(drop_b), 0);

    // fairness: both channels push 3 on the same edges
    reset_big();
    for (int j = 0; j < 3; j++) begin
      drive_b(0, 20 + j, 1, 1);
      drive_b(1, 60 + j, 2, 2);
      if_b.req_valid = 2'b11;
      tick();
      if (j == 0) k = cyc;
    end
    if_b.req_valid = 2'b00;
    repeat (10) tick();
    check("t2_plot_count", log_b.size(), 6);
    if (log_b.size() == 6) begin
      for (int p = 0; p < 6; p++) begin
        check("t2_cycle", log_b[p].cyc, k + 2 + p);
        check("t2_x", log_b[p].x, (p % 2 == 0) ? 20 + p / 2 : 60 + p / 2);
        check("t2_colour", log_b[p].c, (p % 2 == 0) ? 1 : 2);
      end
    end

    // backpressure during a clear sweep
    reset_big();
    clr_start_b = 1'b1;
    clr_col_b = 3'd7;
    tick();
    clr_start_b = 1'b0;
    acc = 0;
    guard = 0;
    chk4 = 0;
    drive_b(0, 100, 30, 2);
    if_b.req_valid = 2'b01;
    while (acc < 5 && guard < 25000) begin
      @(negedge clock);
      if (chk4) begin
        check("t3_ready_after_4th", int'(if_b.req_ready[0]), 0);
        chk4 = 0;
      end
      r = if_b.req_ready[0];
      tick();
      guard++;
      if (r) begin
        acc++;
        if (acc == 4) chk4 = 1;
        drive_b(0, 100 + acc, 30, 2);
        if (acc == 5) if_b.req_valid = 2'b00;
      end
    end
    if_b.req_valid = 2'b00;
    check("t3_accepts", acc, 5);
    guard = 0;
    while (busy_b && guard < 25000) begin
      tick();
      guard++;
    end
    check("t3_clear_done", int'(busy_b), 0);
    repeat (10) tick();
    sel.delete();
    foreach (log_b[i]) if (log_b[i].c == 2) sel.push_back(log_b[i]);
    check("t3_queued_plots", sel.size(), 5);
    if (sel.size() == 5)
      for (int p = 0; p < 5; p++) check("t3_order_x", sel[p].x, 100 + p);

    // clipping and saturation
    reset_big();
    drive_b(1, 160, 0, 1);
    if_b.req_valid = 2'b10;
    tick();
    if_b.req_valid = 2'b00;
    repeat (4) tick();
    check("t4_no_plot", log_b.size(), 0);
    check("t4_drop1", int'(drop_b), 1);
    drive_b(0, 5, 120, 1);
    drive_b(1, 6, 120, 1);
    if_b.req_valid = 2'b11;
    tick();
    if_b.req_valid = 2'b00;
    tick();
    check("t4_drop3", int'(drop_b), 3);
    log_b.delete();
    drive_b(0, 159, 119, 3);
    if_b.req_valid = 2'b01;
    tick();
    if_b.req_valid = 2'b00;
    repeat (5) tick();
    check("t4_edge_count", log_b.size(), 1);
    if (log_b.size() == 1) begin
      check("t4_edge_x", log_b[0].x, 159);
      check("t4_edge_y", log_b[0].y, 119);
    end
    check("t4_edge_drop", int'(drop_b), 3);
    drive_b(0, 5, 120, 1);
    if_b.req_valid = 2'b01;
    tick();
    check("t4_drop4", int'(drop_b), 4);
    if_b.req_valid = 2'b11;
    for (int i = 0; i < 32765; i++) tick();
    if_b.req_valid = 2'b00;
    check("t4_drop65534", int'(drop_b), 65534);
    if_b.req_valid = 2'b11;
    tick();
    if_b.req_valid = 2'b00;
    check("t4_sat_pair", int'(drop_b), 65535);
    if_b.req_valid = 2'b10;
    tick();
    if_b.req_valid = 2'b00;
    tick();
    check("t4_sat_hold", int'(drop_b), 65535);

    // full sweep on the 4x2 screen
    log_s.delete();
    clr_start_s = 1'b1;
    clr_col_s = 3'd6;
    tick();
    clr_start_s = 1'b0;
    clr_col_s = 3'd0;
    k = cyc;
    bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (busy_s) bcnt++;
    end
    tick();
    check("t5_busy_cycles", bcnt, 8);
    check("t5_plot_count", log_s.size(), 8);
    if (log_s.size() == 8) begin
      for (int p = 0; p < 8; p++) begin
        check("t5_cycle", log_s[p].cyc, k + 1 + p);
        check("t5_x", log_s[p].x, p % 4);
        check("t5_y", log_s[p].y, p / 4);
        check("t5_colour", log_s[p].c, 6);
      end
    end

    // reset in the middle of a sweep with a full channel FIFO
    log_s.delete();
    clr_start_s = 1'b1;
    clr_col_s = 3'd5;
    if_s.req_valid = 2'b10;
    for (int j = 0; j < 4; j++) begin
      if_s.req_x = 16'(j) << 8;
      if_s.req_y = '0;
      if_s.req_colour = 6'b001_000;
      tick();
      clr_start_s = 1'b0;
    end
    if_s.req_valid = 2'b00;
    @(negedge clock);
    check("t6_third_pixel_x", int'(if_s.vga_x), 2);
    check("t6_third_pixel_plot", int'(if_s.vga_plot), 1);
    check("t6_full_before", int'(if_s.req_ready), 1);
    #1;
    rn_s = 1'b0;
    #1;
    check("t6_rst_plot", int'(if_s.vga_plot), 0);
    check("t6_rst_busy", int'(busy_s), 0);
    check("t6_rst_ready", int'(if_s.req_ready), 3);
    check("t6_rst_drop", int'(drop_s), 0);
    tick();
    rn_s = 1'b1;
    log_s.delete();
    repeat (12) tick();
    check("t6_no_stale", log_s.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Multi-client front end for vga_adapter: buffers plot requests from NUM_CH independent drawing engines in per-channel FIFOs.
- Clips out-of-range coordinates and arbitrates round-robin.
- Issues at most one registered plot per cycle on the adapter's x/y/colour/plot interface.
- Provides a built-in screen-clear sweep mode that fills the whole frame with one colour.

Parameters:
NUM_CH, 2, number of client channels (1..8)
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COLOUR_W, 3, colour width
X_MAX, 159, largest legal x
Y_MAX, 119, largest legal y
FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel FIFO not full
req_x  in  NUM_CH*X_W  packed x, channel i at [i*X_W +: X_W]
req_y  in  NUM_CH*Y_W  packed y, same packing
req_colour  in  NUM_CH*COLOUR_W  packed colour, same packing
clear_start  in  1  pulse: begin full-screen clear
clear_colour  in  COLOUR_W  colour for clear, sampled with clear_start
clear_busy  out  1  high while clear sweep runs
vga_x  out  X_W  to adapter x
vga_y  out  Y_W  to adapter y
vga_colour  out  COLOUR_W  to adapter colour
vga_plot  out  1  to adapter plot, one cycle per pixel
drop_count  out  16  saturating count of clipped requests

Behaviour:
- Clock `clock`; reset `resetn`, asynchronous, active-low.
- Reset values:
  - vga_x, vga_y, vga_colour, vga_plot, clear_busy, drop_count = 0.
  - All FIFOs empty, so req_ready = all 1s.
  - Round-robin pointer = NUM_CH-1, so channel 0 wins first.
  - FSM = IDLE.
- Accept/clip:
  - A transfer on channel i occurs on an edge where req_valid[i] && req_ready[i].
  - req_ready[i] = !full[i], with no same-cycle pop credit.
  - If x > X_MAX or y > Y_MAX, the transfer completes but is not written; drop_count increments, saturating at 65535.
  - Several channels dropping on one edge add their count in a single update, still saturating.
- FIFOs:
  - Ordinary synchronous FIFO per channel; pointer width log2(FIFO_DEPTH)+1 for full/empty.
  - No write-to-read bypass: an entry written at edge k is poppable no earlier than the cycle after edge k.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the occupancy unchanged.
- FSM IDLE:
  - Each cycle, grant the first non-empty channel strictly after the pointer, wrapping modulo NUM_CH.
  - Pop it and update the pointer to the granted index.
  - On the next edge, register its x/y/colour into vga_x/vga_y/vga_colour and set vga_plot=1.
  - If no FIFO is non-empty, vga_plot=0 and vga_x/y/colour hold their values.
  - Latency: accepted at edge k, earliest vga_plot=1 is after edge k+2.
- FSM IDLE -> CLEAR:
  - Taken on clear_start=1 in IDLE; clear_colour is latched and sweep counters cx=0, cy=0 are set.
  - No FIFO pop occurs that cycle.
  - clear_busy goes high after the same edge.
- FSM CLEAR:
  - Each cycle output plot (cx, cy, latched colour) with vga_plot=1.
  - Sweep is row-major: cx increments; when cx==X_MAX, cx wraps to 0 and cy increments.
  - After pixel (X_MAX, Y_MAX) is plotted, return to IDLE and drop clear_busy.
  - Exactly (X_MAX+1)*(Y_MAX+1) consecutive plot cycles are produced.
  - FIFOs keep accepting (subject to full) but are not popped.
  - clear_start during CLEAR is ignored.
  - Arbitration resumes on the first IDLE cycle.
- resetn assertion mid-operation (including mid-clear):
  - Immediately forces all reset values; FIFO contents are discarded and the sweep is aborted.
- Coordinate widths: the X_MAX and Y_MAX comparisons use full req widths, with no truncation.

Test Plan:
1. Single request: ch0 (x=10, y=20, colour=5) accepted at edge k -> vga_plot=1 for exactly one cycle after edge k+2 with x=10, y=20, colour=5; drop_count=0.
2. Fairness: ch0 and ch1 each push 3 entries on the same edges -> 6 consecutive plot cycles ordered ch0, ch1, ch0, ch1, ch0, ch1.
3. Backpressure: start a clear, then push 5 entries on ch0 -> req_ready[0]=0 after the 4th accept and the 5th request is held; after clear_busy falls, the 4 queued entries plot in FIFO order, then the 5th.
4. Clipping: ch1 sends x=160, y=0 -> accepted, no plot, drop_count=1; ch0 and ch1 both send y=120 on the same edge -> drop_count=3; a forced 65535 stays at 65535 on a further drop.
5. Clear sweep with X_MAX=3, Y_MAX=1, clear_colour=6 -> 8 consecutive plots (0,0), (1,0), (2,0), (3,0), (0,1), (1,1), (2,1), (3,1), all colour 6; clear_busy high for exactly 8 cycles.
6. Reset mid-clear: resetn=0 during the 3rd sweep pixel -> vga_plot=0, clear_busy=0, req_ready=all 1s, drop_count=0 without waiting for a clock edge; after release, no stale plots appear.
